// File: rtl/seq_check_pkg.sv
// rtl/seq_check_pkg.sv - shared state type and default pattern for the sequence checker
package seq_check_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } seq_state_t;

   localparam int         DEF_PAT_LEN = 8;
   localparam logic [7:0] DEF_PATTERN = 8'hB2;

endpackage

// File: rtl/seq_check_rx_if.sv
// rtl/seq_check_rx_if.sv - serial bit stream in, lock/match/error status out
interface seq_check_rx_if #(
   parameter int CNT_W = 16
);

   logic             en;
   logic             seq_in;
   logic             locked;
   logic             match;
   logic             err;
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output en,
      output seq_in,
      input  locked,
      input  match,
      input  err,
      input  match_cnt
   );

   modport slave (
      input  en,
      input  seq_in,
      output locked,
      output match,
      output err,
      output match_cnt
   );

endinterface

// File: rtl/seq_shift_win.sv
// rtl/seq_shift_win.sv - EN-qualified bit history and fill counter; presents the window including the current bit
module seq_shift_win #(
   parameter int PAT_LEN = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic               seq_in_i,
   output logic [PAT_LEN-1:0] nxt_o,
   output logic               fill_ok_o
);

   localparam int FW = $clog2(PAT_LEN + 1);

   // Only PAT_LEN-1 bits of history are kept; the oldest window bit is never compared again.
   logic [PAT_LEN-2:0] hist_q;
   logic [FW-1:0]      fill_q;

   assign nxt_o     = {hist_q, seq_in_i};
   assign fill_ok_o = (fill_q >= FW'(PAT_LEN - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (en_i) begin
         hist_q <= nxt_o[PAT_LEN-2:0];
         if (fill_q != FW'(PAT_LEN)) begin
            fill_q <= fill_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_check_rx.sv
// rtl/seq_check_rx.sv - hunts for PATTERN, locks to its period and checks every bit
// SEQ_CHECK_CNT_EN builds the saturating MATCH counter; otherwise match_cnt is 0.
module seq_check_rx
   import seq_check_pkg::*;
#(
   parameter int               PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
   parameter int               ERR_MAX = 3,
   parameter int               CNT_W   = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   seq_check_rx_if.slave rx_if
);

   localparam int PH_W = $clog2(PAT_LEN);
   localparam int EW   = $clog2(ERR_MAX + 1);
   // Bit-reversed so the phase counter indexes the expected bit directly.
   localparam logic [PAT_LEN-1:0] PAT_REV = {<<{PATTERN}};

   logic [PAT_LEN-1:0] nxt_w;
   logic               fill_ok_w;

   seq_check_pkg::seq_state_t state_q;
   logic [PH_W-1:0]           phase_q;
   logic [EW-1:0]             err_cnt_q;
   logic                      per_err_q;
   logic                      locked_q;
   logic                      match_q;
   logic                      err_q;

   logic last_ph;
   logic bad_bit;
   logic hunt_hit;
   logic err_max_hit;
   logic match_d;
   logic err_d;

   seq_shift_win #(
      .PAT_LEN (PAT_LEN)
   ) u_win (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (rx_if.en),
      .seq_in_i  (rx_if.seq_in),
      .nxt_o     (nxt_w),
      .fill_ok_o (fill_ok_w)
   );

   always_comb begin
      last_ph     = (phase_q == PH_W'(PAT_LEN - 1));
      bad_bit     = (rx_if.seq_in != PAT_REV[phase_q]);
      hunt_hit    = fill_ok_w && (nxt_w == PATTERN);
      err_max_hit = bad_bit && (err_cnt_q == EW'(ERR_MAX - 1));
      match_d     = 1'b0;
      err_d       = 1'b0;
      if (rx_if.en) begin
         if (state_q == HUNT) begin
            match_d = hunt_hit;
         end else begin
            match_d = last_ph && !bad_bit && !per_err_q;
            err_d   = bad_bit;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= HUNT;
         phase_q   <= '0;
         err_cnt_q <= '0;
         per_err_q <= 1'b0;
         locked_q  <= 1'b0;
         match_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         match_q <= match_d;
         err_q   <= err_d;
         if (rx_if.en) begin
            case (state_q)
               HUNT: begin
                  if (hunt_hit) begin
                     state_q   <= LOCK;
                     locked_q  <= 1'b1;
                     phase_q   <= '0;
                     err_cnt_q <= '0;
                     per_err_q <= 1'b0;
                  end
               end
               LOCK: begin
                  phase_q <= last_ph ? '0 : phase_q + 1'b1;
                  if (err_max_hit) begin
                     state_q   <= HUNT;
                     locked_q  <= 1'b0;
                     err_cnt_q <= '0;
                     per_err_q <= 1'b0;
                  end else begin
                     // A clean period forgives earlier errors; a dirty one keeps the tally.
                     if (bad_bit) begin
                        err_cnt_q <= err_cnt_q + 1'b1;
                     end else if (last_ph && !per_err_q) begin
                        err_cnt_q <= '0;
                     end
                     if (last_ph) begin
                        per_err_q <= 1'b0;
                     end else if (bad_bit) begin
                        per_err_q <= 1'b1;
                     end
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign rx_if.locked = locked_q;
   assign rx_if.match  = match_q;
   assign rx_if.err    = err_q;

`ifdef SEQ_CHECK_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign rx_if.match_cnt = cnt_q;
`else
   assign rx_if.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_check_rx.sv
// tb/tb_seq_check_rx.sv - directed bench for seq_check_rx (16-bit and 2-bit counter instances)
module tb_seq_check_rx;
   import seq_check_pkg::*;

`ifdef SEQ_CHECK_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_check_rx_if #(.CNT_W(16)) rx_if ();
   seq_check_rx_if #(.CNT_W(2))  rx2_if ();

   assign rx2_if.en     = rx_if.en;
   assign rx2_if.seq_in = rx_if.seq_in;

   seq_check_rx #(
      .PAT_LEN (8),
      .PATTERN (8'hB2),
      .ERR_MAX (3),
      .CNT_W   (16)
   ) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .rx_if  (rx_if)
   );

   seq_check_rx #(
      .PAT_LEN (8),
      .PATTERN (8'hB2),
      .ERR_MAX (3),
      .CNT_W   (2)
   ) u_dut2 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .rx_if  (rx2_if)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int n_match = 0;
   int n_err   = 0;
   int n_both  = 0;
   int last_match_cyc = 0;
   int match_gap = 0;
   int m0, e0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int cnt_exp(input int n, input int w);
      int mx;
      mx = (1 << w) - 1;
      if (!CNT_EN) return 0;
      return (n > mx) ? mx : n;
   endfunction

   task automatic check_cnt(input string tag, input int n);
      check({tag, "_cnt16"}, int'(rx_if.match_cnt), cnt_exp(n, 16));
      check({tag, "_cnt2"},  int'(rx2_if.match_cnt), cnt_exp(n, 2));
   endtask

   task automatic feed(input logic b, input logic e);
      @(negedge clk);
      rx_if.en     = e;
      rx_if.seq_in = b;
      @(posedge clk);
      #1;
      cyc++;
      if (rx_if.match) begin
         n_match++;
         match_gap      = cyc - last_match_cyc;
         last_match_cyc = cyc;
      end
      if (rx_if.err) n_err++;
      if (rx_if.match && rx_if.err) n_both++;
   endtask

   task automatic feed_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) feed(v[i], 1'b1);
   endtask

   initial begin
      logic [7:0] v;
      rx_if.en     = 1'b0;
      rx_if.seq_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_locked", int'(rx_if.locked), 0);
      check("rst_match",  int'(rx_if.match), 0);
      check("rst_err",    int'(rx_if.err), 0);
      check_cnt("rst", 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Lock acquisition: 3 zeros then B2 x4
      for (int i = 0; i < 3; i++) feed(1'b0, 1'b1);
      v = 8'hB2;
      for (int i = 7; i >= 1; i--) feed(v[i], 1'b1);
      check("hunt_not_locked", int'(rx_if.locked), 0);
      feed(v[0], 1'b1);
      check("lock_cycle", cyc, 11);
      check("lock_locked", int'(rx_if.locked), 1);
      check("lock_match", int'(rx_if.match), 1);
      repeat (3) feed_byte(8'hB2);
      check("s1_matches", n_match, 4);
      check("s1_last_match", last_match_cyc, 35);
      check("s1_gap", match_gap, 8);
      check("s1_errs", n_err, 0);
      check_cnt("s1", 4);

      // Single bad bit, then a clean period
      m0 = n_match; e0 = n_err;
      feed_byte(8'hB2 ^ 8'h10);
      check("s2_err_pulses", n_err - e0, 1);
      check("s2_no_match", n_match - m0, 0);
      check("s2_locked", int'(rx_if.locked), 1);
      m0 = n_match; e0 = n_err;
      feed_byte(8'hB2);
      check("s2_clean_match", n_match - m0, 1);
      check("s2_clean_err", n_err - e0, 0);
      check_cnt("s2", 5);

      // Three bad bits (1, 3, 5) lose lock; an aligned B2 re-locks
      m0 = n_match; e0 = n_err;
      v = 8'hB2 ^ 8'h54;
      for (int i = 7; i >= 3; i--) feed(v[i], 1'b1);
      check("s3_pre_drop", int'(rx_if.locked), 1);
      feed(v[2], 1'b1);
      check("s3_drop", int'(rx_if.locked), 0);
      check("s3_drop_err", int'(rx_if.err), 1);
      feed(v[1], 1'b1);
      feed(v[0], 1'b1);
      check("s3_err_pulses", n_err - e0, 3);
      check("s3_no_match", n_match - m0, 0);
      feed_byte(8'hB2);
      check("s3_relock", int'(rx_if.locked), 1);
      check("s3_relock_match", int'(rx_if.match), 1);
      check_cnt("s3", 6);

      // EN toggling: data on EN-low cycles is the inverted bit and must be ignored
      m0 = n_match; e0 = n_err;
      v = 8'hB2;
      for (int p = 0; p < 2; p++) begin
         for (int i = 7; i >= 0; i--) begin
            feed(v[i], 1'b1);
            feed(~v[i], 1'b0);
         end
      end
      check("s4_matches", n_match - m0, 2);
      check("s4_errs", n_err - e0, 0);
      check("s4_gap", match_gap, 16);
      check("s4_en_low_quiet", int'(rx_if.match), 0);
      check("s4_locked", int'(rx_if.locked), 1);
      check_cnt("s4", 8);

      // Asynchronous reset pulse mid-lock
      for (int i = 7; i >= 4; i--) feed(v[i], 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("s5_rst_locked", int'(rx_if.locked), 0);
      check("s5_rst_match", int'(rx_if.match), 0);
      check("s5_rst_err", int'(rx_if.err), 0);
      check_cnt("s5_rst", 0);
      rst_n = 1'b1;
      for (int i = 7; i >= 1; i--) feed(v[i], 1'b1);
      check("s5_no_early_lock", int'(rx_if.locked), 0);
      feed(v[0], 1'b1);
      check("s5_relock", int'(rx_if.locked), 1);
      check_cnt("s5", 1);

      // Counter saturation on the 2-bit instance
      repeat (4) feed_byte(8'hB2);
      check_cnt("s6", 5);

      check("never_both", n_both, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seq_check_rx.md
# seq_check_rx

Serial sequence checker: the receive end of the on-chip periodic sequence generator's `SEQ_OUT` line. It hunts for a programmable PAT_LEN-bit pattern in the incoming bit stream, then locks to its period. Once locked it checks every bit, flags mismatches, and drops lock after ERR_MAX errors. It sits directly on the generator's serial output, in the same clock domain, one bit per enabled clock.

## Interface
- PAT_LEN, 8: pattern length in bits, ≥ 2.
- PATTERN, 8'hB2: expected pattern. Bit PAT_LEN-1 is received first.
- ERR_MAX, 3: mismatched bits within the lock that force a return to hunting, ≥ 1.
- CNT_W, 16: width of MATCH_CNT.
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  bit-valid qualifier; SEQ_IN is sampled only when high (tie high for one bit per clock).
- SEQ_IN  in  1  serial data from the generator.
- LOCKED  out  1  high while in LOCK.
- MATCH  out  1  one-cycle pulse per complete, error-free pattern.
- ERR  out  1  one-cycle pulse per mismatched bit while locked.
- MATCH_CNT  out  CNT_W  saturating count of MATCH pulses.

## Operation
- Reset values: state HUNT, window 0, fill 0, phase 0, err_cnt 0, LOCKED/MATCH/ERR 0, MATCH_CNT 0.
- Window register: on EN, win ← {win[PAT_LEN-2:0], SEQ_IN}. Shifts in both states.
- nxt = {win[PAT_LEN-2:0], SEQ_IN}.
- Fill counter saturates at PAT_LEN and is cleared only by reset.

States:
- **HUNT**:
  - On EN with fill ≥ PAT_LEN-1 and nxt == PATTERN: go to LOCK, set phase 0 and err_cnt 0, pulse MATCH.
  - Otherwise stay in HUNT.
- **LOCK**: on EN, compare SEQ_IN against PATTERN[PAT_LEN-1-phase], then advance phase modulo PAT_LEN.
  - Mismatch: pulse ERR, increment err_cnt, set per-period error flag.
  - err_cnt reaching ERR_MAX: go to HUNT on the same edge and clear err_cnt. No MATCH is issued for that period.
  - End of period (phase == PAT_LEN-1) with the period flag clear: pulse MATCH and clear err_cnt.
  - The flag clears at every period end.
- EN low: state, window, phase, fill and counters hold. MATCH/ERR are 0.
- MATCH_CNT: increments on each MATCH and saturates at 2^CNT_W−1.
- The window keeps its contents on a return to HUNT. Re-lock can occur on the next aligned pattern without refilling.

## Timing
- All outputs are registered. MATCH/ERR/LOCKED change on the edge that samples the relevant bit and are visible in the following cycle.
- Lock latency: LOCKED rises 1 cycle after the edge sampling the last bit of the first complete pattern.
- Locked, EN=1: MATCH period is exactly PAT_LEN cycles.
- Loss of lock: LOCKED falls 1 cycle after the edge sampling the ERR_MAX-th bad bit. ERR pulses on that edge as well.
- ERR and MATCH are never high together.
- Asynchronous RST_N assertion mid-operation clears everything immediately. The first sample is taken on the first rising edge after deassertion.

## Configuration
- SEQ_CHECK_CNT_EN defined: MATCH_CNT counter is built as above.
- SEQ_CHECK_CNT_EN undefined: no counter flops; MATCH_CNT is tied to 0.
- All other behaviour is identical with or without the macro.

## Structure
- seq_check_pkg: state typedef {HUNT, LOCK} and default PATTERN/PAT_LEN constants shared with the generator bench.
- One sub-module, seq_shift_win: the EN-qualified window shift register plus fill counter, exporting win, nxt and a fill_ok flag.
- FSM, phase/err logic and the counter live in the top module.

## Test plan
- Reset, feed 0,0,0 then 8'hB2 repeated 4×, EN=1 → LOCKED high in cycle 12, MATCH at cycles 12/20/28/36, MATCH_CNT=4.
- Locked; invert one bit of period 3 → single ERR pulse, no MATCH for that period, LOCKED stays 1. Next clean period → MATCH, err_cnt 0.
- Locked; invert bits 1, 3, 5 of one period → three ERR pulses, LOCKED falls 1 cycle after the third. A subsequent aligned 8'hB2 re-locks.
- Locked; EN toggled 1/0 each cycle while 8'hB2 is streamed on EN-high cycles → MATCH every 16 cycles, no ERR.
- RST_N low for 1 ns mid-lock (asynchronous, off-edge) → all outputs 0 immediately, MATCH_CNT=0. Re-lock requires 8 fresh bits.
- CNT_W=2, macro defined, 5 clean periods → MATCH_CNT saturates at 3. Macro undefined → MATCH_CNT stays 0.
